// File: rtl/execute_stage.sv
// execute_stage: RV32I EX stage - operand forwarding, ALU, branch resolve, EX/MEM register.
// Latency: alu/branch/pass-through outputs are combinational; exmem_* follow one clk later.
// Backpressure: none; the EX/MEM register captures on every rising clk (no stall/enable).
// Ports: clk/rst (async active-high, clears exmem_* only); ID/EX operands, indices, funct
//        fields and control bits in; forwardA/forwardB select rf / EX-MEM / MEM-WB sources;
//        combinational alu_result_out, store data, branch taken/target, pass-through
//        rd/control out; exmem_* registered copies for the MEM stage.
module execute_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic [31:0] rs1_data_in,
   input  logic [31:0] rs2_data_in,
   input  logic [31:0] imm_in,
   input  logic [4:0]  rs1_in,
   input  logic [4:0]  rs2_in,
   input  logic [4:0]  rd_in,
   input  logic [2:0]  funct3_in,
   input  logic        funct7_5_in,
   input  logic        RegWrite_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        MemToReg_in,
   input  logic        ALUSrc_in,
   input  logic        Branch_in,
   input  logic [1:0]  ALUOp_in,
   input  logic [1:0]  forwardA,
   input  logic [1:0]  forwardB,
   input  logic [31:0] ex_mem_alu_result,
   input  logic [31:0] wb_data,
   output logic [31:0] alu_result_out,
   output logic [31:0] rs2_data_forwarded_out,
   output logic [4:0]  rd_out,
   output logic        RegWrite_out,
   output logic        MemRead_out,
   output logic        MemWrite_out,
   output logic        MemToReg_out,
   output logic        branch_taken_out,
   output logic [31:0] branch_target_out,
   output logic [31:0] exmem_alu_result,
   output logic [31:0] exmem_rs2_data,
   output logic [4:0]  exmem_rd,
   output logic        exmem_RegWrite,
   output logic        exmem_MemRead,
   output logic        exmem_MemWrite,
   output logic        exmem_MemToReg
);

   logic [31:0] w_fwd_a, w_fwd_b, w_op_b, w_alu, w_sum, w_diff;
   logic        w_cond, w_br_lt, w_br_ltu;
   logic [4:0]  w_shamt;

   // rs1/rs2 indices belong to the hazard unit; kept on the port list only.
   logic        w_unused;
   assign w_unused = ^{rs1_in, rs2_in};

   // Encoding 11 is treated like 00 (register-file value).
   always_comb begin
      case (forwardA)
         2'b10:   w_fwd_a = ex_mem_alu_result;
         2'b01:   w_fwd_a = wb_data;
         default: w_fwd_a = rs1_data_in;
      endcase
   end

   always_comb begin
      case (forwardB)
         2'b10:   w_fwd_b = ex_mem_alu_result;
         2'b01:   w_fwd_b = wb_data;
         default: w_fwd_b = rs2_data_in;
      endcase
   end

   assign w_op_b  = ALUSrc_in ? imm_in : w_fwd_b;
   assign w_sum   = w_fwd_a + w_op_b;
   assign w_diff  = w_fwd_a - w_op_b;
   assign w_shamt = w_op_b[4:0];

   always_comb begin
      w_alu = w_sum;
      case (ALUOp_in)
         2'b00: w_alu = w_sum;
         2'b01: w_alu = w_diff;
         2'b11: w_alu = w_op_b;
         default: begin
            case (funct3_in)
               // SUB only for the R form; ADDI with imm[10]=1 must still add.
               3'b000: w_alu = (funct7_5_in && !ALUSrc_in) ? w_diff : w_sum;
               3'b001: w_alu = w_fwd_a << w_shamt;
               3'b010: w_alu = {31'd0, $signed(w_fwd_a) < $signed(w_op_b)};
               3'b011: w_alu = {31'd0, w_fwd_a < w_op_b};
               3'b100: w_alu = w_fwd_a ^ w_op_b;
               3'b101: w_alu = funct7_5_in ? 32'($signed(w_fwd_a) >>> w_shamt)
                                           : (w_fwd_a >> w_shamt);
               3'b110: w_alu = w_fwd_a | w_op_b;
               default: w_alu = w_fwd_a & w_op_b;
            endcase
         end
      endcase
   end

   // Branch compare always uses the two forwarded registers, never the immediate.
   assign w_br_lt  = $signed(w_fwd_a) < $signed(w_fwd_b);
   assign w_br_ltu = w_fwd_a < w_fwd_b;

   always_comb begin
      case (funct3_in)
         3'b000:  w_cond = (w_fwd_a == w_fwd_b);
         3'b001:  w_cond = (w_fwd_a != w_fwd_b);
         3'b100:  w_cond = w_br_lt;
         3'b101:  w_cond = !w_br_lt;
         3'b110:  w_cond = w_br_ltu;
         3'b111:  w_cond = !w_br_ltu;
         default: w_cond = 1'b0;
      endcase
   end

   assign alu_result_out         = w_alu;
   assign rs2_data_forwarded_out = w_fwd_b;
   assign rd_out                 = rd_in;
   assign RegWrite_out           = RegWrite_in;
   assign MemRead_out            = MemRead_in;
   assign MemWrite_out           = MemWrite_in;
   assign MemToReg_out           = MemToReg_in;
   assign branch_taken_out       = Branch_in & w_cond;
   assign branch_target_out      = pc_in + imm_in;

   // EX/MEM pipeline register
   logic [31:0] r_alu, r_rs2;
   logic [4:0]  r_rd;
   logic        r_regwrite, r_memread, r_memwrite, r_memtoreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_memtoreg <= 1'b0;
      end else begin
         r_alu      <= w_alu;
         r_rs2      <= w_fwd_b;
         r_rd       <= rd_in;
         r_regwrite <= RegWrite_in;
         r_memread  <= MemRead_in;
         r_memwrite <= MemWrite_in;
         r_memtoreg <= MemToReg_in;
      end
   end

   assign exmem_alu_result = r_alu;
   assign exmem_rs2_data   = r_rs2;
   assign exmem_rd         = r_rd;
   assign exmem_RegWrite   = r_regwrite;
   assign exmem_MemRead    = r_memread;
   assign exmem_MemWrite   = r_memwrite;
   assign exmem_MemToReg   = r_memtoreg;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and random stimulus for execute_stage with a scoreboard queue.
// Latency: combinational outputs checked 1ns after drive; exmem_* checked 1ns after next posedge.
// Backpressure: none.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_in, rs1_data_in, rs2_data_in, imm_in;
   logic [4:0]  rs1_in, rs2_in, rd_in;
   logic [2:0]  funct3_in;
   logic        funct7_5_in;
   logic        RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in, Branch_in;
   logic [1:0]  ALUOp_in, forwardA, forwardB;
   logic [31:0] ex_mem_alu_result, wb_data;
   logic [31:0] alu_result_out, rs2_data_forwarded_out, branch_target_out;
   logic [4:0]  rd_out, exmem_rd;
   logic        RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out, branch_taken_out;
   logic [31:0] exmem_alu_result, exmem_rs2_data;
   logic        exmem_RegWrite, exmem_MemRead, exmem_MemWrite, exmem_MemToReg;

   execute_stage dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .rs1_data_in(rs1_data_in),
      .rs2_data_in(rs2_data_in), .imm_in(imm_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
      .rd_in(rd_in), .funct3_in(funct3_in), .funct7_5_in(funct7_5_in),
      .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .MemToReg_in(MemToReg_in), .ALUSrc_in(ALUSrc_in), .Branch_in(Branch_in),
      .ALUOp_in(ALUOp_in), .forwardA(forwardA), .forwardB(forwardB),
      .ex_mem_alu_result(ex_mem_alu_result), .wb_data(wb_data),
      .alu_result_out(alu_result_out), .rs2_data_forwarded_out(rs2_data_forwarded_out),
      .rd_out(rd_out), .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out),
      .MemWrite_out(MemWrite_out), .MemToReg_out(MemToReg_out),
      .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out),
      .exmem_alu_result(exmem_alu_result), .exmem_rs2_data(exmem_rs2_data),
      .exmem_rd(exmem_rd), .exmem_RegWrite(exmem_RegWrite), .exmem_MemRead(exmem_MemRead),
      .exmem_MemWrite(exmem_MemWrite), .exmem_MemToReg(exmem_MemToReg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] st;
      logic [4:0]  rd;
      logic [3:0]  ctl;
      logic        taken;
      logic [31:0] tgt;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_fwd(input logic [1:0] s, input logic [31:0] r);
      if (s == 2'b10)      return ex_mem_alu_result;
      else if (s == 2'b01) return wb_data;
      else                 return r;
   endfunction

   // Signed compare via sign-bit flip, so it does not lean on $signed.
   function automatic logic m_lts(input logic [31:0] a, input logic [31:0] b);
      return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
   endfunction

   function automatic exp_t model();
      exp_t        e;
      logic [31:0] a, b, ob;
      int          sh;
      logic        c;
      a  = m_fwd(forwardA, rs1_data_in);
      b  = m_fwd(forwardB, rs2_data_in);
      ob = ALUSrc_in ? imm_in : b;
      sh = int'(ob[4:0]);
      if (ALUOp_in == 2'b00)      e.alu = a + ob;
      else if (ALUOp_in == 2'b01) e.alu = a - ob;
      else if (ALUOp_in == 2'b11) e.alu = ob;
      else begin
         case (funct3_in)
            3'd0: e.alu = (funct7_5_in && !ALUSrc_in) ? a - ob : a + ob;
            3'd1: e.alu = a << sh;
            3'd2: e.alu = m_lts(a, ob) ? 32'd1 : 32'd0;
            3'd3: e.alu = (a < ob) ? 32'd1 : 32'd0;
            3'd4: e.alu = a ^ ob;
            3'd5: e.alu = (a >> sh) | ((funct7_5_in && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            3'd6: e.alu = a | ob;
            default: e.alu = a & ob;
         endcase
      end
      case (funct3_in)
         3'd0: c = (a == b);
         3'd1: c = (a != b);
         3'd4: c = m_lts(a, b);
         3'd5: c = !m_lts(a, b);
         3'd6: c = (a < b);
         3'd7: c = (a >= b);
         default: c = 1'b0;
      endcase
      e.taken = Branch_in && c;
      e.tgt   = pc_in + imm_in;
      e.st    = b;
      e.rd    = rd_in;
      e.ctl   = {RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in};
      return e;
   endfunction

   task automatic clear_inputs();
      pc_in = 0; rs1_data_in = 0; rs2_data_in = 0; imm_in = 0;
      rs1_in = 0; rs2_in = 0; rd_in = 0; funct3_in = 0; funct7_5_in = 0;
      RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0; MemToReg_in = 0;
      ALUSrc_in = 0; Branch_in = 0; ALUOp_in = 0; forwardA = 0; forwardB = 0;
      ex_mem_alu_result = 0; wb_data = 0;
   endtask

   task automatic chk_exmem_zero(input string tag);
      chk({tag, ".alu"}, exmem_alu_result, 0);
      chk({tag, ".st"},  exmem_rs2_data, 0);
      chk({tag, ".rd"},  exmem_rd, 0);
      chk({tag, ".ctl"}, {exmem_RegWrite, exmem_MemRead, exmem_MemWrite, exmem_MemToReg}, 0);
   endtask

   // Called just after a negedge with inputs driven; returns just after the next negedge.
   task automatic step(input string tag);
      exp_t e;
      sb_q.push_back(model());
      #1;
      e = sb_q[$];
      chk({tag, ".alu"}, alu_result_out, e.alu);
      chk({tag, ".st"},  rs2_data_forwarded_out, e.st);
      chk({tag, ".tk"},  branch_taken_out, e.taken);
      chk({tag, ".tgt"}, branch_target_out, e.tgt);
      chk({tag, ".pass"}, {rd_out, RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out},
          {e.rd, e.ctl});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 1, 0);
      end else begin
         e = sb_q.pop_front();
         chk({tag, ".xm_alu"}, exmem_alu_result, e.alu);
         chk({tag, ".xm_st"},  exmem_rs2_data, e.st);
         chk({tag, ".xm_rd"},  exmem_rd, e.rd);
         chk({tag, ".xm_ctl"}, {exmem_RegWrite, exmem_MemRead, exmem_MemWrite, exmem_MemToReg},
             e.ctl);
      end
      @(negedge clk);
   endtask

   task automatic add_case();
      clear_inputs();
      ALUOp_in = 2'b10; rs1_data_in = 10; rs2_data_in = 20; rd_in = 3; RegWrite_in = 1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state with live inputs present
      add_case();
      @(posedge clk); #1;
      chk_exmem_zero("reset");
      chk("rst_comb_alu", alu_result_out, 30);
      @(negedge clk);
      rst = 1'b0;

      // R-type ADD then the registered copy
      add_case();
      #1; chk("add", alu_result_out, 30);
      step("add");
      chk("add_xm_alu", exmem_alu_result, 30);
      chk("add_xm_rd", exmem_rd, 3);
      chk("add_xm_rw", exmem_RegWrite, 1);

      // ADDI, with funct7_5=1 still adding in the I form
      clear_inputs(); ALUOp_in = 2'b10; ALUSrc_in = 1; rs1_data_in = 5; imm_in = 7;
      #1; chk("addi", alu_result_out, 12);
      step("addi");
      funct7_5_in = 1;
      #1; chk("addi_f7", alu_result_out, 12);
      step("addi_f7");

      // Forwarding A sources
      clear_inputs(); ALUSrc_in = 1; imm_in = 1; forwardA = 2'b10;
      ex_mem_alu_result = 42; wb_data = 7;
      #1; chk("fwdA_exmem", alu_result_out, 43);
      step("fwdA_exmem");
      forwardA = 2'b01; ex_mem_alu_result = 9; wb_data = 42;
      #1; chk("fwdA_wb", alu_result_out, 43);
      step("fwdA_wb");
      forwardA = 2'b11;
      #1; chk("fwdA_11", alu_result_out, 1);
      step("fwdA_11");

      // Branches
      clear_inputs(); ALUOp_in = 2'b01; pc_in = 200; rs1_data_in = 15; rs2_data_in = 15;
      imm_in = 16; Branch_in = 1;
      #1; chk("beq_tk", branch_taken_out, 1); chk("beq_tgt", branch_target_out, 216);
      step("beq");
      funct3_in = 3'b001;
      #1; chk("bne_tk", branch_taken_out, 0); chk("bne_tgt", branch_target_out, 216);
      step("bne");
      funct3_in = 3'b000; Branch_in = 0;
      #1; chk("nobr_tk", branch_taken_out, 0); chk("nobr_tgt", branch_target_out, 216);
      step("nobr");
      // BLT on registers while ALUSrc selects the immediate
      funct3_in = 3'b100; Branch_in = 1; ALUSrc_in = 1; rs1_data_in = 32'hFFFF_FFFF;
      rs2_data_in = 1; imm_in = 32'hFFFF_FFF0;
      #1; chk("blt_alusrc", branch_taken_out, 1); chk("blt_tgt", branch_target_out, 184);
      step("blt_alusrc");

      // SRAI, SLT vs SLTU
      clear_inputs(); ALUOp_in = 2'b10; funct3_in = 3'b101; funct7_5_in = 1; ALUSrc_in = 1;
      rs1_data_in = 32'h8000_0000; imm_in = 32'h0000_0404;
      #1; chk("srai", alu_result_out, 32'hF800_0000);
      step("srai");
      clear_inputs(); ALUOp_in = 2'b10; funct3_in = 3'b010;
      rs1_data_in = 32'hFFFF_FFFF; rs2_data_in = 1;
      #1; chk("slt", alu_result_out, 1);
      step("slt");
      funct3_in = 3'b011;
      #1; chk("sltu", alu_result_out, 0);
      step("sltu");

      // Random vectors through the scoreboard
      for (int i = 0; i < 200; i++) begin
         pc_in = $urandom; imm_in = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40);
         rs1_data_in = $urandom; rs2_data_in = $urandom_range(0, 3) == 0 ? rs1_data_in : $urandom;
         ex_mem_alu_result = $urandom; wb_data = $urandom;
         rd_in = 5'($urandom); rs1_in = 5'($urandom); rs2_in = 5'($urandom);
         funct3_in = 3'($urandom); funct7_5_in = 1'($urandom);
         {RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in, Branch_in} = 6'($urandom);
         ALUOp_in = 2'($urandom); forwardA = 2'($urandom); forwardB = 2'($urandom);
         step("rnd");
      end

      // Reset mid-cycle: pending capture discarded, async clear, comb path unaffected
      add_case(); rd_in = 9; MemWrite_in = 1;
      #2; rst = 1'b1;
      #1; chk_exmem_zero("midrst_async");
      chk("midrst_comb", alu_result_out, 30);
      @(posedge clk); #1;
      chk_exmem_zero("midrst_edge");
      @(negedge clk);
      rst = 1'b0;
      step("post_rst");
      chk("post_rst_rd", exmem_rd, 9);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
